// File: rtl/tlp_host_pkg.sv
// Shared constants and types for the host-side TLP responder.
package tlp_host_pkg;

  localparam logic [6:0] MWR32 = 7'h40;
  localparam logic [6:0] MWR64 = 7'h60;
  localparam logic [6:0] MRD32 = 7'h00;
  localparam logic [6:0] MRD64 = 7'h20;
  localparam logic [6:0] CPLD  = 7'h4A;

  typedef enum logic [1:0] {IDLE, GRANT, RX, CPL} tlp_state_e;

  typedef struct packed {
    logic [6:0]  fmt_type;
    logic [61:0] addr;
    logic [10:0] len;
    logic [7:0]  be;
    logic [1:0]  attr;
    logic [23:0] tid;
  } tlp_hdr_t;

  function automatic logic is_mwr(input logic [6:0] ft);
    return (ft == MWR32) || (ft == MWR64);
  endfunction

  function automatic logic is_mrd(input logic [6:0] ft);
    return (ft == MRD32) || (ft == MRD64);
  endfunction

  // A zero length field encodes the maximum of 1024 DWs.
  function automatic logic [10:0] dw_len(input logic [9:0] l);
    return (l == 10'd0) ? 11'd1024 : {1'b0, l};
  endfunction

endpackage

// File: rtl/tlp_host_responder_if.sv
// Endpoint TLP request (tlp_out) and completion (tlp_in) bundle.
interface tlp_host_responder_if;
  logic        tlp_out_req_to_send;
  logic        tlp_out_grant;
  logic [6:0]  tlp_out_fmt_type;
  logic [9:0]  tlp_out_length_in_dw;
  logic        tlp_out_src_rdy_n;
  logic        tlp_out_dst_rdy_n;
  logic [31:0] tlp_out_data;
  logic [61:0] tlp_out_address;
  logic [7:0]  tlp_out_ldwbe_fdwbe;
  logic [1:0]  tlp_out_attr;
  logic [23:0] tlp_out_transaction_id;
  logic [12:0] tlp_out_byte_count;
  logic [6:0]  tlp_out_lower_address;
  logic        tlp_in_valid;
  logic        tlp_in_accept_data;
  logic [6:0]  tlp_in_fmt_type;
  logic [31:0] tlp_in_address;
  logic [10:0] tlp_in_length_in_dw;
  logic [1:0]  tlp_in_attr;
  logic [23:0] tlp_in_transaction_id;
  logic [31:0] tlp_in_data;
  logic [3:0]  tlp_in_byte_en;
  logic [12:0] tlp_in_byte_count;

  modport master (
    output tlp_out_req_to_send, tlp_out_fmt_type, tlp_out_length_in_dw, tlp_out_src_rdy_n,
           tlp_out_data, tlp_out_address, tlp_out_ldwbe_fdwbe, tlp_out_attr,
           tlp_out_transaction_id, tlp_out_byte_count, tlp_out_lower_address,
           tlp_in_accept_data,
    input  tlp_out_grant, tlp_out_dst_rdy_n, tlp_in_valid, tlp_in_fmt_type, tlp_in_address,
           tlp_in_length_in_dw, tlp_in_attr, tlp_in_transaction_id, tlp_in_data,
           tlp_in_byte_en, tlp_in_byte_count
  );

  modport slave (
    input  tlp_out_req_to_send, tlp_out_fmt_type, tlp_out_length_in_dw, tlp_out_src_rdy_n,
           tlp_out_data, tlp_out_address, tlp_out_ldwbe_fdwbe, tlp_out_attr,
           tlp_out_transaction_id, tlp_out_byte_count, tlp_out_lower_address,
           tlp_in_accept_data,
    output tlp_out_grant, tlp_out_dst_rdy_n, tlp_in_valid, tlp_in_fmt_type, tlp_in_address,
           tlp_in_length_in_dw, tlp_in_attr, tlp_in_transaction_id, tlp_in_data,
           tlp_in_byte_en, tlp_in_byte_count
  );
endinterface

// File: rtl/tlp_host_ram.sv
// Byte-enabled DW RAM: synchronous write port, asynchronous read port, contents never reset.
module tlp_host_ram #(
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wbe,
    input  logic [RAM_AW-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tlp_host_responder.sv
// Host model for the endpoint TLP port: grants requests, stores MWr payloads, answers MRd with CplD.
module tlp_host_responder
    import tlp_host_pkg::*;
#(
    parameter int unsigned RAM_AW = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tlp_host_responder_if.slave  tlp,
    input  logic                 host_stall,
    output logic [CNT_W-1:0]     wr_count,
    output logic [CNT_W-1:0]     rd_count,
    output logic                 unsup_pulse
);

    tlp_state_e state_q, state_d;
    tlp_hdr_t   hdr_q;
    logic              first_q;
    logic [10:0]       rem_q, cpl_rem_q;
    logic [RAM_AW-1:0] widx_q, rptr_q;
    logic              grant_q, dst_rdy_n_q, valid_q, unsup_q;
    logic [6:0]        in_fmt_q;
    logic [31:0]       in_addr_q;
    logic [10:0]       in_len_q;
    logic [1:0]        in_attr_q;
    logic [23:0]       in_tid_q;
    logic [12:0]       in_bc_q;
    logic [3:0]        in_be_q;
    logic [CNT_W-1:0]  wr_count_q, rd_count_q;

    logic              beat, last_beat, ram_we, cpl_load, cpl_accept, cpl_last;
    logic [6:0]        cur_fmt;
    logic [10:0]       in_len, beat_cnt;
    logic [RAM_AW-1:0] ram_waddr;
    logic [3:0]        ram_wbe;
    logic [31:0]       ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (tlp.tlp_out_req_to_send) state_d = GRANT;
            GRANT: state_d = RX;
            RX: begin
                if (beat) begin
                    if (first_q && is_mrd(cur_fmt)) state_d = CPL;
                    else if (last_beat)             state_d = IDLE;
                end
            end
            CPL:   if (cpl_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat     = (state_q == RX) && !tlp.tlp_out_src_rdy_n && !dst_rdy_n_q;
        cur_fmt  = first_q ? tlp.tlp_out_fmt_type : hdr_q.fmt_type;
        in_len   = dw_len(tlp.tlp_out_length_in_dw);
        // Unsupported TLPs without payload (fmt[6]=0) are a single header beat.
        beat_cnt = (is_mwr(tlp.tlp_out_fmt_type) || tlp.tlp_out_fmt_type[6]) ? in_len : 11'd1;
        if (first_q) last_beat = !is_mrd(cur_fmt) && (beat_cnt == 11'd1);
        else         last_beat = (rem_q == 11'd1);
        ram_we     = beat && is_mwr(cur_fmt);
        ram_waddr  = first_q ? tlp.tlp_out_address[RAM_AW-1:0] : widx_q;
        ram_wbe    = first_q ? tlp.tlp_out_ldwbe_fdwbe[3:0]
                   : ((rem_q == 11'd1) ? hdr_q.be[7:4] : 4'hF);
        cpl_load   = (state_q == CPL) && !valid_q;
        cpl_accept = valid_q && tlp.tlp_in_accept_data;
        cpl_last   = cpl_accept && (cpl_rem_q == 11'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_q       <= '0;
            first_q     <= 1'b0;
            rem_q       <= '0;
            cpl_rem_q   <= '0;
            widx_q      <= '0;
            rptr_q      <= '0;
            grant_q     <= 1'b0;
            dst_rdy_n_q <= 1'b1;
            valid_q     <= 1'b0;
            unsup_q     <= 1'b0;
            in_fmt_q    <= '0;
            in_addr_q   <= '0;
            in_len_q    <= '0;
            in_attr_q   <= '0;
            in_tid_q    <= '0;
            in_bc_q     <= '0;
            in_be_q     <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            grant_q     <= (state_q == IDLE) && tlp.tlp_out_req_to_send;
            dst_rdy_n_q <= (state_d == RX) ? host_stall : 1'b1;
            unsup_q     <= beat && last_beat && !is_mwr(cur_fmt);
            if (state_q == GRANT) first_q <= 1'b1;
            else if (beat)        first_q <= 1'b0;
            if (beat) begin
                if (first_q) begin
                    hdr_q <= '{fmt_type: tlp.tlp_out_fmt_type, addr: tlp.tlp_out_address,
                               len: in_len, be: tlp.tlp_out_ldwbe_fdwbe,
                               attr: tlp.tlp_out_attr, tid: tlp.tlp_out_transaction_id};
                    rem_q <= beat_cnt - 11'd1;
                end else begin
                    rem_q <= rem_q - 11'd1;
                end
                widx_q <= ram_waddr + 1'b1;
            end
            if (beat && last_beat && is_mwr(cur_fmt)) wr_count_q <= wr_count_q + 1'b1;
            if (cpl_load) begin
                valid_q   <= 1'b1;
                in_fmt_q  <= CPLD;
                in_addr_q <= {hdr_q.addr[29:0], 2'b00};
                in_len_q  <= hdr_q.len;
                in_attr_q <= hdr_q.attr;
                in_tid_q  <= hdr_q.tid;
                in_bc_q   <= {hdr_q.len, 2'b00};
                in_be_q   <= 4'hF;
                rptr_q    <= hdr_q.addr[RAM_AW-1:0];
                cpl_rem_q <= hdr_q.len;
            end else if (cpl_accept) begin
                rptr_q    <= rptr_q + 1'b1;
                cpl_rem_q <= cpl_rem_q - 11'd1;
                if (cpl_last) begin
                    valid_q    <= 1'b0;
                    rd_count_q <= rd_count_q + 1'b1;
                end
            end
        end
    end

    tlp_host_ram #(.RAM_AW(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (tlp.tlp_out_data),
        .wbe   (ram_wbe),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    assign tlp.tlp_out_grant         = grant_q;
    assign tlp.tlp_out_dst_rdy_n     = dst_rdy_n_q;
    assign tlp.tlp_in_valid          = valid_q;
    assign tlp.tlp_in_fmt_type       = in_fmt_q;
    assign tlp.tlp_in_address        = in_addr_q;
    assign tlp.tlp_in_length_in_dw   = in_len_q;
    assign tlp.tlp_in_attr           = in_attr_q;
    assign tlp.tlp_in_transaction_id = in_tid_q;
    assign tlp.tlp_in_byte_en        = in_be_q;
    assign tlp.tlp_in_byte_count     = in_bc_q;
    // RAM is not reset, so mask its read data outside a completion.
    assign tlp.tlp_in_data           = valid_q ? ram_rdata : '0;
    assign wr_count                  = wr_count_q;
    assign rd_count                  = rd_count_q;
    assign unsup_pulse               = unsup_q;

    logic unused_bits;
    assign unused_bits = ^{tlp.tlp_out_byte_count, tlp.tlp_out_lower_address,
                           hdr_q.addr[61:30], hdr_q.be[3:0]};

endmodule

// File: tb/tb_tlp_host_responder.sv
// Bench for tlp_host_responder: vector table plus directed multi-cycle sequences.
module tb_tlp_host_responder;
    import tlp_host_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_stall;
    logic [15:0] wr_count, rd_count;
    logic        unsup_pulse;

    tlp_host_responder_if tlp ();

    always #5 clk = ~clk;

    tlp_host_responder #(.RAM_AW(10), .CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tlp         (tlp),
        .host_stall  (host_stall),
        .wr_count    (wr_count),
        .rd_count    (rd_count),
        .unsup_pulse (unsup_pulse)
    );

    typedef struct {
        logic [61:0] waddr;
        logic [61:0] raddr;
        logic        is64;
        logic [31:0] pre;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    int          passed = 0;
    int          total = 0;
    logic        stall_toggle = 1'b0;
    logic [31:0] beat_q[$];
    logic [31:0] exp_q[$];
    vec_t        vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        if (stall_toggle) host_stall = ~host_stall;
    endtask

    task automatic request();
        tlp.tlp_out_req_to_send = 1'b1;
        @(negedge clk);
        chk("grant_rise", tlp.tlp_out_grant, 1);
        tlp.tlp_out_req_to_send = 1'b0;
        @(negedge clk);
        chk("grant_fall", tlp.tlp_out_grant, 0);
    endtask

    task automatic send(input logic [6:0] fmt, input logic [61:0] addr, input logic [9:0] len,
                        input logic [7:0] be, input logic [1:0] attr, input logic [23:0] tid,
                        output int cycles);
        int n;
        request();
        tlp.tlp_out_fmt_type       = fmt;
        tlp.tlp_out_address        = addr;
        tlp.tlp_out_length_in_dw   = len;
        tlp.tlp_out_ldwbe_fdwbe    = be;
        tlp.tlp_out_attr           = attr;
        tlp.tlp_out_transaction_id = tid;
        cycles = 0;
        for (int i = 0; i < beat_q.size(); i++) begin
            tlp.tlp_out_data      = beat_q[i];
            tlp.tlp_out_src_rdy_n = 1'b0;
            n = 0;
            while (tlp.tlp_out_dst_rdy_n !== 1'b0 && n < 64) begin
                step();
                n++;
                cycles++;
            end
            if (n >= 64) begin
                chk("beat_timeout", 64'(n), 0);
                break;
            end
            step();
            cycles++;
        end
        tlp.tlp_out_src_rdy_n = 1'b1;
        beat_q.delete();
    endtask

    task automatic wr(input logic [61:0] a, input logic [9:0] len, input logic [7:0] be,
                      input logic is64, output int cycles);
        send(is64 ? MWR64 : MWR32, a, len, be, 2'b00, 24'h0, cycles);
    endtask

    task automatic collect(input logic [61:0] a, input int len, input logic [23:0] tid,
                           input logic [1:0] attr, input int stall_beat);
        int n = 0;
        logic [31:0] ea;
        ea = {a[29:0], 2'b00};
        while (tlp.tlp_in_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("cpl_timeout", 64'(n), 0);
            exp_q.delete();
            return;
        end
        chk("cpl_fmt", tlp.tlp_in_fmt_type, 7'h4A);
        chk("cpl_len", tlp.tlp_in_length_in_dw, 64'(len));
        chk("cpl_bc", tlp.tlp_in_byte_count, 64'(len * 4));
        chk("cpl_tid", tlp.tlp_in_transaction_id, tid);
        chk("cpl_attr", tlp.tlp_in_attr, attr);
        chk("cpl_addr", tlp.tlp_in_address, ea);
        chk("cpl_be", tlp.tlp_in_byte_en, 4'hF);
        for (int i = 0; i < len; i++) begin
            if (i == stall_beat) begin
                tlp.tlp_in_accept_data = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", tlp.tlp_in_valid, 1);
                    chk("hold_data", tlp.tlp_in_data, exp_q[0]);
                end
            end
            chk("cpl_valid", tlp.tlp_in_valid, 1);
            chk("cpl_data", tlp.tlp_in_data, exp_q.pop_front());
            tlp.tlp_in_accept_data = 1'b1;
            @(negedge clk);
        end
        tlp.tlp_in_accept_data = 1'b0;
        chk("valid_drop", tlp.tlp_in_valid, 0);
    endtask

    task automatic rd(input logic [61:0] a, input int len, input logic [23:0] tid,
                      input logic [1:0] attr, input logic is64, input int stall_beat);
        int cyc;
        beat_q.push_back(32'hDEAD0000);
        send(is64 ? MRD64 : MRD32, a, 10'(len), 8'hFF, attr, tid, cyc);
        collect(a, len, tid, attr, stall_beat);
    endtask

    initial begin
        int n;
        int cyc;
        vecs[0] = '{62'h200, 62'h200, 1'b0, 32'hFFFFFFFF, 32'hAABBCCDD, 4'h3, 32'hFFFFCCDD};
        vecs[1] = '{62'h201, 62'h201, 1'b0, 32'h00000000, 32'h12345678, 4'h8, 32'h12000000};
        vecs[2] = '{62'h202, 62'h202, 1'b0, 32'h00000000, 32'h12345678, 4'h0, 32'h00000000};
        vecs[3] = '{62'h203, 62'h203, 1'b0, 32'h55555555, 32'hDEADBEEF, 4'h5, 32'h55AD55EF};
        // 64-bit write far above the RAM; index wraps to DW 4.
        vecs[4] = '{62'h1_0000_0404, 62'h004, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};

        reset_n = 1'b0;
        host_stall = 1'b0;
        tlp.tlp_out_req_to_send = 1'b0;
        tlp.tlp_out_src_rdy_n = 1'b1;
        tlp.tlp_out_fmt_type = '0;
        tlp.tlp_out_length_in_dw = '0;
        tlp.tlp_out_data = '0;
        tlp.tlp_out_address = '0;
        tlp.tlp_out_ldwbe_fdwbe = '0;
        tlp.tlp_out_attr = '0;
        tlp.tlp_out_transaction_id = '0;
        tlp.tlp_out_byte_count = '0;
        tlp.tlp_out_lower_address = '0;
        tlp.tlp_in_accept_data = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_grant", tlp.tlp_out_grant, 0);
        chk("rst_dst_rdy_n", tlp.tlp_out_dst_rdy_n, 1);
        chk("rst_valid", tlp.tlp_in_valid, 0);
        chk("rst_fmt", tlp.tlp_in_fmt_type, 0);
        chk("rst_addr", tlp.tlp_in_address, 0);
        chk("rst_len", tlp.tlp_in_length_in_dw, 0);
        chk("rst_attr", tlp.tlp_in_attr, 0);
        chk("rst_tid", tlp.tlp_in_transaction_id, 0);
        chk("rst_data", tlp.tlp_in_data, 0);
        chk("rst_be", tlp.tlp_in_byte_en, 0);
        chk("rst_bc", tlp.tlp_in_byte_count, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_unsup", unsup_pulse, 0);
        reset_n = 1'b1;
        @(negedge clk);

        beat_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        wr(62'h40, 10'd4, 8'hFF, 1'b0, cyc);
        chk("wr_count_1", wr_count, 1);
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        rd(62'h40, 4, 24'h0A0B05, 2'b10, 1'b0, -1);
        chk("rd_count_1", rd_count, 1);

        // len-1 writes: ldwbe is F, so only fdwbe may take effect
        for (int i = 0; i < 5; i++) begin
            beat_q.push_back(vecs[i].pre);
            wr(vecs[i].waddr, 10'd1, 8'hFF, vecs[i].is64, cyc);
            beat_q.push_back(vecs[i].data);
            wr(vecs[i].waddr, 10'd1, {4'hF, vecs[i].be}, vecs[i].is64, cyc);
            exp_q.push_back(vecs[i].exp);
            rd(vecs[i].raddr, 1, 24'h000100 + 24'(i), 2'b01, vecs[i].is64, -1);
        end
        chk("wr_count_tbl", wr_count, 11);
        chk("rd_count_tbl", rd_count, 6);

        beat_q = '{32'h0, 32'h0, 32'h0};
        wr(62'h90, 10'd3, 8'hFF, 1'b0, cyc);
        beat_q = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};
        wr(62'h90, 10'd3, 8'h3C, 1'b0, cyc);
        exp_q = '{32'hAAAA0000, 32'hBBBBBBBB, 32'h0000CCCC};
        rd(62'h90, 3, 24'h00ABCD, 2'b00, 1'b0, -1);

        stall_toggle = 1'b1;
        for (int i = 0; i < 8; i++) beat_q.push_back(32'h50000000 + 32'(i));
        wr(62'h80, 10'd8, 8'hFF, 1'b0, cyc);
        stall_toggle = 1'b0;
        host_stall = 1'b0;
        chk("stall_slows", 64'(cyc >= 14), 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h50000000 + 32'(i));
        rd(62'h80, 8, 24'h123456, 2'b11, 1'b0, 3);
        chk("wr_count_stall", wr_count, 14);
        chk("rd_count_stall", rd_count, 8);

        beat_q = '{32'h0BAD0BAD};
        send(7'h04, 62'h40, 10'd1, 8'hFF, 2'b00, 24'h000777, cyc);
        chk("cfgrd_unsup_hi", unsup_pulse, 1);
        @(negedge clk);
        chk("cfgrd_unsup_lo", unsup_pulse, 0);
        beat_q = '{32'h1, 32'h2, 32'h3};
        send(7'h42, 62'h40, 10'd3, 8'hFF, 2'b00, 24'h000778, cyc);
        chk("iowr_unsup_hi", unsup_pulse, 1);
        @(negedge clk);
        chk("iowr_unsup_lo", unsup_pulse, 0);
        chk("unsup_wr_count", wr_count, 14);
        chk("unsup_rd_count", rd_count, 8);

        beat_q = '{32'hDEAD0000};
        send(MRD32, 62'h40, 10'd4, 8'hFF, 2'b00, 24'h000999, cyc);
        n = 0;
        while (tlp.tlp_in_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_data0", tlp.tlp_in_data, 32'h11);
        tlp.tlp_in_accept_data = 1'b1;
        @(negedge clk);
        tlp.tlp_in_accept_data = 1'b0;
        chk("pre_rst_data1", tlp.tlp_in_data, 32'h22);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_valid", tlp.tlp_in_valid, 0);
        chk("midrst_data", tlp.tlp_in_data, 0);
        chk("midrst_dst_rdy_n", tlp.tlp_out_dst_rdy_n, 1);
        chk("midrst_wr_count", wr_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        rd(62'h40, 4, 24'h000001, 2'b00, 1'b0, -1);
        chk("post_rst_rd_count", rd_count, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
